// File: rtl/local_sp_arbiter_if.sv
// rtl/local_sp_arbiter_if.sv - request, response and bank signals of the scratchpad arbiter
interface local_sp_arbiter_if #(
  parameter int DataWidth    = 256,
  parameter int AddressWidth = 11
);
  logic                    wr_valid;
  logic                    wr_ready;
  logic [AddressWidth-1:0] wr_addr;
  logic [DataWidth-1:0]    wr_data;
  logic                    rd_req_valid;
  logic                    rd_req_ready;
  logic [AddressWidth-1:0] rd_req_addr;
  logic                    rd_resp_valid;
  logic                    rd_resp_ready;
  logic [DataWidth-1:0]    rd_resp_data;
  logic [AddressWidth-1:0] mem_address0;
  logic                    mem_ce0;
  logic                    mem_we0;
  logic [DataWidth-1:0]    mem_d0;
  logic [DataWidth-1:0]    mem_q0;
  logic                    idle;

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_req_valid, rd_req_addr, rd_resp_ready, mem_q0,
    output wr_ready, rd_req_ready, rd_resp_valid, rd_resp_data,
    output mem_address0, mem_ce0, mem_we0, mem_d0, idle
  );

  modport master (
    output wr_valid, wr_addr, wr_data, rd_req_valid, rd_req_addr, rd_resp_ready, mem_q0,
    input  wr_ready, rd_req_ready, rd_resp_valid, rd_resp_data,
    input  mem_address0, mem_ce0, mem_we0, mem_d0, idle
  );
endinterface

// File: rtl/local_sp_arbiter.sv
// rtl/local_sp_arbiter.sv - single-port scratchpad arbiter: round-robin write/read issue, read latency tracking, credited response FIFO
module local_sp_arbiter #(
  parameter int DataWidth    = 256,
  parameter int AddressWidth = 11,
  parameter int RdLatency    = 2,
  parameter int RespDepth    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  local_sp_arbiter_if.slave bus
);
  localparam int PtrWidth = $clog2(RespDepth);
  localparam int CntWidth = PtrWidth + 1;
  localparam logic [CntWidth-1:0] CreditMax = CntWidth'(RespDepth);

  typedef enum logic {LAST_WRITE, LAST_READ} last_grant_e;

  last_grant_e             r_last_grant;
  last_grant_e             w_last_grant_nxt;
  logic                    w_rd_eligible;
  logic                    w_wr_grant;
  logic                    w_rd_grant;
  logic [CntWidth-1:0]     r_credits;
  logic                    r_ce;
  logic                    r_we;
  logic [AddressWidth-1:0] r_addr;
  logic [DataWidth-1:0]    r_d0;
  logic                    w_rd_issue;
  logic [RdLatency-1:0]    r_rd_pipe;
  logic                    r_cap_valid;
  logic [DataWidth-1:0]    r_cap_data;
  logic [DataWidth-1:0]    r_fifo [RespDepth];
  logic [CntWidth-1:0]     r_wptr;
  logic [CntWidth-1:0]     r_rptr;
  logic [CntWidth-1:0]     w_count;
  logic [CntWidth-1:0]     w_count_nxt;
  logic                    r_resp_valid;
  logic                    w_push;
  logic                    w_pop;

  // Credits cover every read from grant until its FIFO pop, so a push can never find the FIFO full.
  assign w_rd_eligible = bus.rd_req_valid && (r_credits < CreditMax);

  always_comb begin
    w_wr_grant       = 1'b0;
    w_rd_grant       = 1'b0;
    w_last_grant_nxt = r_last_grant;
    if (reset_n) begin
      if (bus.wr_valid && w_rd_eligible) begin
        if (r_last_grant == LAST_WRITE) w_rd_grant = 1'b1;
        else                            w_wr_grant = 1'b1;
      end else begin
        w_wr_grant = bus.wr_valid;
        w_rd_grant = w_rd_eligible;
      end
    end
    if (w_wr_grant)      w_last_grant_nxt = LAST_WRITE;
    else if (w_rd_grant) w_last_grant_nxt = LAST_READ;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_last_grant <= LAST_WRITE;
    else          r_last_grant <= w_last_grant_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ce   <= 1'b0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_d0   <= '0;
    end else begin
      r_ce <= w_wr_grant | w_rd_grant;
      r_we <= w_wr_grant;
      if (w_wr_grant) begin
        r_addr <= bus.wr_addr;
        r_d0   <= bus.wr_data;
      end else if (w_rd_grant) begin
        r_addr <= bus.rd_req_addr;
      end
    end
  end

  // The valid pipe mirrors the bank's output pipeline; its tail marks the cycle q0 is valid.
  assign w_rd_issue = r_ce & ~r_we;
  assign w_push     = r_cap_valid;
  assign w_pop      = r_resp_valid & bus.rd_resp_ready;
  assign w_count    = r_wptr - r_rptr;
  assign w_count_nxt = w_count + CntWidth'(w_push) - CntWidth'(w_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_pipe    <= '0;
      r_cap_valid  <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_resp_valid <= 1'b0;
      r_credits    <= '0;
    end else begin
      r_rd_pipe    <= RdLatency'({r_rd_pipe, w_rd_issue});
      r_cap_valid  <= r_rd_pipe[RdLatency-1];
      r_wptr       <= r_wptr + CntWidth'(w_push);
      r_rptr       <= r_rptr + CntWidth'(w_pop);
      r_resp_valid <= (w_count_nxt != '0);
      r_credits    <= r_credits + CntWidth'(w_rd_grant) - CntWidth'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (r_rd_pipe[RdLatency-1]) r_cap_data <= bus.mem_q0;
    if (w_push)                 r_fifo[r_wptr[PtrWidth-1:0]] <= r_cap_data;
  end

  assign bus.wr_ready      = w_wr_grant;
  assign bus.rd_req_ready  = w_rd_grant;
  assign bus.rd_resp_valid = r_resp_valid;
  assign bus.rd_resp_data  = r_fifo[r_rptr[PtrWidth-1:0]];
  assign bus.mem_address0  = r_addr;
  assign bus.mem_ce0       = r_ce;
  assign bus.mem_we0       = r_we;
  assign bus.mem_d0        = r_d0;
  assign bus.idle          = !r_ce && (r_credits == '0);
endmodule

// File: tb/tb_local_sp_arbiter.sv
// tb/tb_local_sp_arbiter.sv - randomized bench for local_sp_arbiter against a queue-based transaction model
module tb_local_sp_arbiter;
  localparam int DW = 256;
  localparam int AW = 11;
  localparam int RL = 2;
  localparam int RD = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  local_sp_arbiter_if #(.DataWidth(DW), .AddressWidth(AW)) bus ();

  local_sp_arbiter #(.DataWidth(DW), .AddressWidth(AW), .RdLatency(RL), .RespDepth(RD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input int i);
    logic [DW-1:0] w;
    for (int k = 0; k < 8; k++) w[k*32 +: 32] = (i * 32'h9E3779B1) ^ (k * 32'h85EBCA6B) ^ 32'h1234_5678;
    if (i == 5) w = {32{8'hA5}};
    return w;
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom();
    return w;
  endfunction

  // Scratchpad bank: RL-stage read pipeline, write on ce0&we0.
  logic [DW-1:0] bank [2**AW];
  logic [DW-1:0] qpipe [RL];
  bit bank_loaded = 1'b0;
  always @(posedge clk) begin
    if (!bank_loaded) begin
      for (int i = 0; i < 2**AW; i++) bank[i] <= init_word(i);
      bank_loaded <= 1'b1;
    end else if (bus.mem_ce0 && bus.mem_we0) begin
      bank[bus.mem_address0] <= bus.mem_d0;
    end
    for (int i = RL-1; i > 0; i--) qpipe[i] <= qpipe[i-1];
    if (bus.mem_ce0 && !bus.mem_we0) qpipe[0] <= bank[bus.mem_address0];
  end
  assign bus.mem_q0 = qpipe[RL-1];

  // Transaction model: memory image updated at grant time, responses queued with their due cycle.
  typedef struct { int t; logic [DW-1:0] d; } resp_t;
  logic [DW-1:0] ref_mem [2**AW];
  resp_t   mq[$];
  bit      model_loaded = 1'b0;
  int      cyc = 0;
  int      m_credits = 0;
  bit      m_last_wr = 1'b1;
  bit      e_ce = 1'b0, e_we = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_d = '0;
  bit      m_wr_go = 1'b0, m_rd_go = 1'b0, m_pop = 1'b0;
  bit      glog[$];
  int      n_wacc = 0, n_racc = 0, n_pop = 0, n_rvalid = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if (!model_loaded) begin
        for (int i = 0; i < 2**AW; i++) ref_mem[i] <= init_word(i);
        model_loaded <= 1'b1;
      end
      mq.delete();
      m_credits <= 0;
      m_last_wr <= 1'b1;
      e_ce      <= 1'b0;
      e_we      <= 1'b0;
      e_addr    <= '0;
      e_d       <= '0;
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_rd_go) mq.push_back('{cyc + 1 + RL + 2, ref_mem[bus.rd_req_addr]});
      if (m_wr_go) ref_mem[bus.wr_addr] <= bus.wr_data;
      m_credits <= m_credits + int'(m_rd_go) - int'(m_pop);
      if (m_wr_go)      m_last_wr <= 1'b1;
      else if (m_rd_go) m_last_wr <= 1'b0;
      e_ce <= m_wr_go || m_rd_go;
      e_we <= m_wr_go;
      if (m_wr_go) begin
        e_addr <= bus.wr_addr;
        e_d    <= bus.wr_data;
      end else if (m_rd_go) begin
        e_addr <= bus.rd_req_addr;
      end
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk) begin : compare
    bit rd_el;
    bit ev;
    rd_el   = bus.rd_req_valid && (m_credits < RD);
    m_wr_go = 1'b0;
    m_rd_go = 1'b0;
    if (reset_n) begin
      if (bus.wr_valid && rd_el) begin
        if (m_last_wr) m_rd_go = 1'b1;
        else           m_wr_go = 1'b1;
      end else begin
        m_wr_go = bus.wr_valid;
        m_rd_go = rd_el;
      end
    end
    ev = 1'b0;
    if (mq.size() > 0) ev = (mq[0].t <= cyc);
    m_pop = ev && bus.rd_resp_ready;
    chk("wr_ready", DW'(bus.wr_ready), DW'(m_wr_go));
    chk("rd_req_ready", DW'(bus.rd_req_ready), DW'(m_rd_go));
    chk("mem_ce0", DW'(bus.mem_ce0), DW'(e_ce));
    chk("mem_we0", DW'(bus.mem_we0), DW'(e_we));
    chk("mem_address0", DW'(bus.mem_address0), DW'(e_addr));
    chk("mem_d0", bus.mem_d0, e_d);
    chk("rd_resp_valid", DW'(bus.rd_resp_valid), DW'(ev));
    if (ev) chk("rd_resp_data", bus.rd_resp_data, mq[0].d);
    chk("idle", DW'(bus.idle), DW'(!e_ce && m_credits == 0));
    chk("fifo_overflow", DW'(dut.w_push && (dut.w_count == RD)), '0);
    if (bus.wr_ready) begin glog.push_back(1'b0); n_wacc++; end
    if (bus.rd_req_ready) begin glog.push_back(1'b1); n_racc++; end
    if (bus.rd_resp_valid) n_rvalid++;
    if (bus.rd_resp_valid && bus.rd_resp_ready) n_pop++;
  end

  // Stimulus: request queues, presented one head at a time and held until the model grants them.
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wreq_t;
  wreq_t         wq[$];
  logic [AW-1:0] rq[$];
  int            rmode = 1;

  task automatic tick(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      if (m_wr_go && wq.size() > 0) void'(wq.pop_front());
      if (m_rd_go && rq.size() > 0) void'(rq.pop_front());
      bus.wr_valid = (wq.size() > 0);
      if (wq.size() > 0) begin
        bus.wr_addr = wq[0].a;
        bus.wr_data = wq[0].d;
      end
      bus.rd_req_valid = (rq.size() > 0);
      if (rq.size() > 0) bus.rd_req_addr = rq[0];
      case (rmode)
        0:       bus.rd_resp_ready = 1'b0;
        1:       bus.rd_resp_ready = 1'b1;
        default: bus.rd_resp_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  endtask

  task automatic drain(input string nm, input int budget);
    int k;
    k = 0;
    while ((wq.size() > 0 || rq.size() > 0 || m_credits != 0 || e_ce) && k < budget) begin
      tick(1);
      k++;
    end
    chk(nm, DW'(k >= budget), '0);
  endtask

  task automatic wait_resp(input string nm, output logic [DW-1:0] d);
    bit ok;
    ok = 1'b0;
    d  = '0;
    for (int k = 0; k < 50 && !ok; k++) begin
      tick(1);
      if (bus.rd_resp_valid) begin
        ok = 1'b1;
        d  = bus.rd_resp_data;
      end
    end
    chk(nm, DW'(ok), DW'(1));
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    wq.delete();
    rq.delete();
    tick(1);
    reset_n = 1'b1;
  endtask

  initial begin : stim
    logic [DW-1:0] d, p, q, a5;
    logic [7:0] g;
    int c0, c1;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_req_valid = 1'b0; bus.rd_req_addr = '0; bus.rd_resp_ready = 1'b1;
    a5 = {32{8'hA5}};

    tick(3);
    chk("rst_idle", DW'(bus.idle), DW'(1));
    chk("rst_mem_ce0", DW'(bus.mem_ce0), '0);
    chk("rst_rd_resp_valid", DW'(bus.rd_resp_valid), '0);
    chk("rst_mem_address0", DW'(bus.mem_address0), '0);
    wq.push_back('{11'd100, rnd_word()});
    tick(1);
    #1;
    chk("rst_wr_ready", DW'(bus.wr_ready), '0);
    reset_n = 1'b1;
    drain("drain_after_reset", 50);

    rq.push_back(11'd5);
    tick(2);
    chk("rd5_ce", DW'(bus.mem_ce0), DW'(1));
    chk("rd5_we", DW'(bus.mem_we0), '0);
    chk("rd5_addr", DW'(bus.mem_address0), DW'(5));
    tick(3);
    chk("rd5_valid_early", DW'(bus.rd_resp_valid), '0);
    tick(1);
    chk("rd5_valid", DW'(bus.rd_resp_valid), DW'(1));
    chk("rd5_data", bus.rd_resp_data, a5);
    drain("drain_rd5", 50);

    p = {8{32'hC0DE_F00D}};
    wq.push_back('{11'h7FF, p});
    tick(2);
    rq.push_back(11'h7FF);
    wait_resp("raw_7ff_timeout", d);
    chk("raw_7ff_data", d, p);
    drain("drain_7ff", 50);
    q = {16{16'h1357}};
    wq.push_back('{11'h000, q});
    rq.push_back(11'h000);
    wait_resp("raw_0_timeout", d);
    chk("raw_0_data", d, q);
    drain("drain_0", 50);

    pulse_reset();
    glog.delete();
    c0 = n_pop;
    for (int i = 0; i < 4; i++) begin
      wq.push_back('{AW'($urandom_range(0, 2**AW-1)), rnd_word()});
      rq.push_back(AW'($urandom_range(0, 2**AW-1)));
    end
    drain("drain_contention", 100);
    g = '0;
    for (int i = 0; i < glog.size() && i < 8; i++) g = {g[6:0], glog[i]};
    chk("contention_order", DW'(g), DW'(8'b1010_1010));
    chk("contention_grants", DW'(glog.size()), DW'(8));
    chk("contention_responses", DW'(n_pop - c0), DW'(4));

    rmode = 0;
    c0 = n_racc;
    c1 = n_pop;
    for (int i = 0; i < 10; i++) rq.push_back(AW'($urandom_range(0, 63)));
    tick(20);
    chk("bp_reads_accepted", DW'(n_racc - c0), DW'(4));
    #1;
    chk("bp_rd_req_ready", DW'(bus.rd_req_ready), '0);
    c0 = n_wacc;
    for (int i = 0; i < 3; i++) wq.push_back('{AW'($urandom_range(0, 63)), rnd_word()});
    tick(10);
    chk("bp_writes_flow", DW'(n_wacc - c0), DW'(3));
    rmode = 1;
    drain("drain_bp", 200);
    chk("bp_responses", DW'(n_pop - c1), DW'(10));

    c0 = n_pop;
    for (int i = 0; i < 100; i++) rq.push_back(AW'($urandom_range(0, 15)));
    for (int i = 0; i < 40; i++) wq.push_back('{AW'($urandom_range(0, 15)), rnd_word()});
    rmode = 0;
    tick(8);
    rmode = 1;
    tick(40);
    rmode = 2;
    drain("drain_random", 3000);
    chk("random_responses", DW'(n_pop - c0), DW'(100));
    rmode = 1;

    c0 = n_racc;
    for (int i = 0; i < 3; i++) rq.push_back(AW'($urandom_range(0, 2**AW-1)));
    tick(4);
    chk("mf_accepted", DW'(n_racc - c0), DW'(3));
    pulse_reset();
    c1 = n_rvalid;
    tick(12);
    chk("mf_no_resp", DW'(n_rvalid - c1), '0);
    chk("mf_idle", DW'(bus.idle), DW'(1));
    chk("mf_credits", DW'(dut.r_credits), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, bad=%0d", bad);
    $fatal(1);
  end
endmodule

// File: doc/local_sp_arbiter.md
# local_sp_arbiter

Arbiter that shares one single-port URAM scratchpad (`local_SP` bank, 256-bit × 2048) between a write requester (loader) and a read requester (kNN distance compute). It accepts one memory operation per cycle and drives the bank's `address0/ce0/we0/d0` from a registered issue stage. It tracks read latency and buffers returned `q0` data in a small response FIFO, so the read consumer can apply backpressure without losing data. Credit-based issue guarantees the FIFO never overflows.

## Interface
Parameters:
- `DataWidth`, 256, scratchpad word width
- `AddressWidth`, 11, scratchpad address width
- `RdLatency`, 2, cycles from `mem_ce0` high (read) to valid `mem_q0`; range 1–4
- `RespDepth`, 4, response FIFO depth and read-credit limit; power of two, ≥ 2

Ports:
- `clk` input 1 — single clock; all logic rising-edge
- `reset_n` input 1 — asynchronous active-low reset, one clock; polarity and synchronicity fixed
- `wr_valid` input 1 — write request pending
- `wr_ready` output 1 — write accepted this cycle
- `wr_addr` input AddressWidth — write address
- `wr_data` input DataWidth — write data
- `rd_req_valid` input 1 — read request pending
- `rd_req_ready` output 1 — read accepted this cycle
- `rd_req_addr` input AddressWidth — read address
- `rd_resp_valid` output 1 — FIFO head valid
- `rd_resp_ready` input 1 — consumer pops head
- `rd_resp_data` output DataWidth — FIFO head data
- `mem_address0` output AddressWidth — to bank `address0`
- `mem_ce0` output 1 — to bank `ce0`
- `mem_we0` output 1 — to bank `we0`
- `mem_d0` output DataWidth — to bank `d0`
- `mem_q0` input DataWidth — from bank `q0`
- `idle` output 1 — no issue pending, no read in flight, FIFO empty

## Operation
- Handshake: transfer on `valid && ready`. Once asserted, valid and payload hold until accepted. Ready is combinational from the valids, the round-robin state and credits.
- `rd_eligible = rd_req_valid && (credits < RespDepth)`. `credits` = reads in flight plus FIFO occupancy.
- Arbitration (per cycle, at most one grant):
  - Only one of `wr_valid` / `rd_eligible` set: grant it.
  - Both set: grant the side not granted last.
  - `last_grant` updates on every grant; reset value = WRITE, so read wins the first contest.
- Issue stage (registered): a grant at edge t sets the mem outputs during cycle t+1.
  - Write: `mem_ce0=1`, `mem_we0=1`, address and data.
  - Read: `mem_ce0=1`, `mem_we0=0`, address. `mem_d0` holds its previous value.
  - No grant: `mem_ce0=0`, `mem_we0=0`. Address and data hold.
- Read tracking: a RdLatency-deep valid shift register is loaded with 1 on read issue. Its output pushes `mem_q0` into the FIFO.
- Credits:
  - +1 on read grant; −1 on FIFO pop.
  - Both in one cycle: unchanged.
  - Width is clog2(RespDepth)+1 bits; never exceeds RespDepth.
- FIFO: RespDepth entries with wrapping read/write pointers. A push while full cannot occur (credit invariant); the bench asserts this. Push and pop in the same cycle are both allowed, including when full or empty (empty: head not yet valid, pop ignored).
- Order: read responses return strictly in request order. A write followed by a read to the same address returns the new data, because the bank is single-port and operations issue in order.
- `idle = !mem_ce0 && credits==0`.

## Timing
- Reset values (asynchronous, while `reset_n`=0): `mem_ce0`=0, `mem_we0`=0, `mem_address0`=0, `mem_d0`=0, `rd_resp_valid`=0, `idle`=1, credits=0, pointers=0, `last_grant`=WRITE.
- `wr_ready` and `rd_req_ready` are 0 during reset.
- Reset mid-operation: in-flight reads and FIFO contents are discarded, with no spurious `rd_resp_valid` after release.
- Throughput: one op per cycle sustained. Alternating grants under constant contention.
- Read latency, request accept (edge t) to `rd_resp_valid`: RdLatency+2 edges; default 4 cycles with an empty FIFO.
- `rd_resp_valid` is registered (FIFO not empty); `rd_resp_data` is the head entry.
- With `rd_resp_ready` stuck at 0, exactly RespDepth reads are accepted, then `rd_req_ready`=0. Writes still flow.

## Test plan
- Reset check: reset → all outputs at reset values. Then one read of addr 5 (preloaded 0xA5…) → `mem_ce0`=1, `mem_we0`=0, addr 5 one cycle after accept; `rd_resp_valid` 4 cycles after accept, data 0xA5….
- Write-then-read: write addr 0x7FF = pattern P, then read 0x7FF → response P. Write addr 0, read 0 back-to-back → new data.
- Contention: both valid for 8 cycles → grants R,W,R,W,R,W,R,W; 4 writes and 4 responses in request order.
- Backpressure: `rd_resp_ready`=0, 10 reads offered → exactly 4 accepted, `rd_req_ready`=0 after. Writes still accepted. Release ready → 4 responses in order, then remaining reads proceed.
- Simultaneous push/pop at full FIFO with steady 1-per-cycle reads and `rd_resp_ready`=1 → no loss or duplication over 100 random addresses; FIFO-overflow assertion never fires.
- Reset mid-flight: pulse `reset_n` low 1 cycle while 3 reads are in flight → no `rd_resp_valid` afterward, credits=0, `idle`=1.
